cordiv_bipolar_acc: RTL and testbench
=====================================

# cordiv_bipolar_acc

Downstream consumer of the bipolar CORDIV divider stage. It converts the divider's serial bipolar quotient bitstream back to a signed binary value by accumulating it over a fixed window of 2^WLOG accepted bits. An optional warm-up discard covers the divider's shift-register settling. A start/done handshake frames each conversion so a controller can run back-to-back divisions.

## Interface
Parameters:
- WLOG, 8, log2 of the accumulation window length in accepted bits.
- SKIP, 0, number of accepted bits discarded after start, before accumulation begins (0..255).

Ports:
- clk  in  1  the block's single clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle request to begin a conversion.
- in_en  in  1  the current in_bit is valid; when low, the cycle is a stall and is not counted.
- in_bit  in  1  bipolar stochastic bit (quotient from the divider).
- busy  out  1  high while in SKIP or ACC.
- done  out  1  one-cycle pulse; result and ones are valid from this cycle.
- ones  out  WLOG+1  count of 1s in the window (0..2^WLOG).
- result  out  WLOG+2 signed  bipolar value, equal to 2*ones − 2^WLOG (range −2^WLOG..+2^WLOG).

## Operation
- FSM states:
  - IDLE: waits for start.
  - SKIP: discards warm-up bits.
  - ACC: accumulates the window.
  - DONE: lasts one cycle.
- IDLE to SKIP on start when SKIP>0. IDLE to ACC on start when SKIP=0.
- SKIP state:
  - Each cycle with in_en=1 increments the skip counter.
  - After SKIP accepted bits, go to ACC. The bit on that final skip cycle is discarded.
- ACC state:
  - Each cycle with in_en=1 increments the window counter.
  - If in_bit=1, that cycle also increments the ones accumulator.
  - On the 2^WLOG-th accepted bit, go to DONE.
- DONE state:
  - done=1. ones and result are registered and reflect the complete window.
  - Next state is IDLE. If start=1 in this same cycle, the next state is SKIP/ACC instead (back-to-back conversion).
- Outputs hold their last values until the next DONE.
- start while busy is ignored. It does not restart and does not queue.
- Counters are cleared when start is accepted.
- The window counter is WLOG+1 bits wide, so the terminal count 2^WLOG is representable without wrap.
- result is computed as (ones << 1) − (1 << WLOG) in WLOG+2-bit two's complement. It never overflows.
- Reset (at any time, including mid-conversion):
  - State goes to IDLE.
  - Counters, ones, result, busy and done all go to 0.
  - Any partial window is lost.

## Timing
- Conversion starts when start is sampled high at clock edge k in IDLE or DONE.
- busy rises after edge k.
- The first counted bit is the one sampled at the first edge after k with in_en=1 (after SKIP discards).
- Latency with in_en held high: done is high in the cycle after edge k+SKIP+2^WLOG. That is SKIP+2^WLOG+1 cycles after start.
- Each low in_en cycle adds exactly one cycle of latency.
- busy falls in the same cycle done rises.
- done never stays high more than one cycle.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package cordiv_pkg holds:
  - the state enum (IDLE, SKIP, ACC, DONE), typedef acc_state_t;
  - the function bipolar_of(ones, WLOG) used for result.
  - The divider-side blocks reuse the same package.
- One natural sub-module, cordiv_win_cnt: a cleared, enabled up-counter with a terminal-count flag. It is instantiated twice, once for skip and once for the window.
- Expected size is about 150–250 lines of RTL.

## Test plan
- WLOG=4, SKIP=0; start, then in_bit=1 and in_en=1 for 16 cycles → done after 17 cycles; ones=16, result=+16.
- WLOG=4; all zeros → ones=0, result=−16. Then alternating 1/0 → ones=8, result=0.
- WLOG=4; in_en low on every third cycle, in_bit=1 → still ones=16, done delayed by the number of stall cycles, result=+16.
- WLOG=4, SKIP=2; first two accepted bits 1, rest 0 → ones=0, result=−16, done at cycle 19.
- Back-to-back and busy checks: start pulsed mid-ACC is ignored and does not change the result; start asserted during the done cycle begins the next conversion with no IDLE cycle.
- rst pulsed at window bit 7 → all outputs 0 immediately. A subsequent start produces a correct full 16-bit window.

Source files
------------

// File: rtl/cordiv_pkg.sv
// Shared types and helpers for the bipolar CORDIV divider chain.
// The state enum and bipolar conversion are reused by the divider-side blocks.
package cordiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SKIP,
      ST_ACC,
      ST_DONE
   } acc_state_t;

   // Widest window any block in the chain supports; callers cast down to their own width.
   localparam int unsigned MAX_WLOG = 16;

   typedef logic        [MAX_WLOG:0]   ones_max_t;
   typedef logic signed [MAX_WLOG+1:0] bip_max_t;

   // Bipolar value of a window: 2*ones - 2^wlog, exact in wlog+2 bits.
   function automatic bip_max_t bipolar_of(input ones_max_t ones, input int unsigned wlog);
      bip_max_t two_ones;
      bip_max_t offset;
      two_ones = bip_max_t'({ones, 1'b0});
      offset   = bip_max_t'(1) <<< wlog;
      return two_ones - offset;
   endfunction

endpackage

// File: rtl/cordiv_bipolar_acc_if.sv
// Conversion handshake and bitstream bus between a controller and the bipolar accumulator.
interface cordiv_bipolar_acc_if #(
   parameter int unsigned WLOG = 8
);
   logic                 start;
   logic                 in_en;
   logic                 in_bit;
   logic                 busy;
   logic                 done;
   logic [WLOG:0]        ones;
   logic signed [WLOG+1:0] result;

   modport master (
      output start, in_en, in_bit,
      input  busy, done, ones, result
   );

   modport slave (
      input  start, in_en, in_bit,
      output busy, done, ones, result
   );
endinterface

// File: rtl/cordiv_win_cnt.sv
// Clearable, enabled up-counter; last_o flags that the next enabled increment hits TERM.
module cordiv_win_cnt #(
   parameter int unsigned W    = 8,
   parameter int unsigned TERM = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   logic [W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign last_o = (cnt_q == W'(TERM - 1));

endmodule

// File: rtl/cordiv_bipolar_acc.sv
// Accumulates a 2^WLOG-bit window of the divider's bipolar quotient stream into
// a count of ones and its signed bipolar value, framed by a start/done handshake.
module cordiv_bipolar_acc
   import cordiv_pkg::*;
#(
   parameter int unsigned WLOG = 8,
   parameter int unsigned SKIP = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   cordiv_bipolar_acc_if.slave   bus
);

   localparam int unsigned SKIP_TERM  = (SKIP > 0) ? SKIP : 1;
   localparam int unsigned WIN        = 1 << WLOG;
   localparam acc_state_t  FIRST_ST   = (SKIP > 0) ? ST_SKIP : ST_ACC;

   typedef logic        [WLOG:0]   ones_t;
   typedef logic signed [WLOG+1:0] res_t;

   acc_state_t state_q;
   ones_t      acc_q;
   ones_t      ones_q;
   ones_t      ones_d;
   res_t       result_q;
   logic       busy_q;
   logic       done_q;

   logic start_ok;
   logic skip_en;
   logic win_en;
   logic skip_last;
   logic win_last;

   // A start is only honoured between conversions; while busy it is dropped.
   assign start_ok = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign skip_en  = (state_q == ST_SKIP) && bus.in_en;
   assign win_en   = (state_q == ST_ACC)  && bus.in_en;
   assign ones_d   = acc_q + {{WLOG{1'b0}}, bus.in_bit};

   cordiv_win_cnt #(
      .W    (8),
      .TERM (SKIP_TERM)
   ) u_skip_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start_ok),
      .en_i   (skip_en),
      .last_o (skip_last)
   );

   cordiv_win_cnt #(
      .W    (WLOG + 1),
      .TERM (WIN)
   ) u_win_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start_ok),
      .en_i   (win_en),
      .last_o (win_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         ones_q   <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  state_q <= FIRST_ST;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_SKIP: begin
               if (skip_en && skip_last) begin
                  state_q <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (win_en) begin
                  acc_q <= ones_d;
                  // The final window bit lands straight in the output registers.
                  if (win_last) begin
                     state_q  <= ST_DONE;
                     ones_q   <= ones_d;
                     result_q <= res_t'(bipolar_of(ones_max_t'(ones_d), WLOG));
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.ones   = ones_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_cordiv_bipolar_acc.sv
// Directed bench for cordiv_bipolar_acc: WLOG=4 instances with SKIP=0 and SKIP=2,
// expected windows queued at start and compared when done pulses.
module tb_cordiv_bipolar_acc;

   localparam int WLOG = 4;
   localparam int WIN  = 1 << WLOG;

   typedef struct {
      int ones;
      int result;
      int start_cyc;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic start_s, in_en_s, in_bit_s;
   bit   sel;
   int   cyc;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   cordiv_bipolar_acc_if #(.WLOG(WLOG)) a_if ();
   cordiv_bipolar_acc_if #(.WLOG(WLOG)) b_if ();

   assign a_if.start  = start_s & ~sel;
   assign a_if.in_en  = in_en_s;
   assign a_if.in_bit = in_bit_s;
   assign b_if.start  = start_s & sel;
   assign b_if.in_en  = in_en_s;
   assign b_if.in_bit = in_bit_s;

   cordiv_bipolar_acc #(.WLOG(WLOG), .SKIP(0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
   cordiv_bipolar_acc #(.WLOG(WLOG), .SKIP(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

   logic              obs_done, obs_busy;
   logic [WLOG:0]     obs_ones;
   logic signed [WLOG+1:0] obs_res;
   assign obs_done = sel ? b_if.done   : a_if.done;
   assign obs_busy = sel ? b_if.busy   : a_if.busy;
   assign obs_ones = sel ? b_if.ones   : a_if.ones;
   assign obs_res  = sel ? b_if.result : a_if.result;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic bit pat_bit(input int pat, input int n);
      case (pat)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (n % 2) == 0;
         default: return n < 2;
      endcase
   endfunction

   function automatic bit is_stall(input int stall_every, input int c);
      return (stall_every > 0) && ((c % stall_every) == stall_every - 1);
   endfunction

   // Starts a conversion from the current cycle and feeds its whole stream.
   task automatic run_conv(input bit s, input int skip, input int pat, input int stall_every, input int mid);
      exp_t e;
      int   n, c, ones, total;
      total = skip + WIN;
      ones  = 0;
      for (int k = skip; k < total; k++) ones += pat_bit(pat, k);
      n = 0;
      c = 0;
      while (n < total) begin
         if (!is_stall(stall_every, c)) n++;
         c++;
      end
      sel     = s;
      start_s = 1'b1;
      in_en_s = 1'b0;
      step();
      start_s     = 1'b0;
      e.ones      = ones;
      e.result    = 2 * ones - WIN;
      e.start_cyc = cyc;
      e.lat       = c;
      sb.push_back(e);
      check("busy_after_start", obs_busy, 1);
      check("done_after_start", obs_done, 0);
      n = 0;
      c = 0;
      while (n < total) begin
         start_s = (c == mid);
         if (is_stall(stall_every, c)) begin
            in_en_s  = 1'b0;
            in_bit_s = 1'b0;
         end else begin
            in_en_s  = 1'b1;
            in_bit_s = pat_bit(pat, n);
            n++;
         end
         c++;
         step();
         if (n < total) check("done_early", obs_done, 0);
      end
      start_s  = 1'b0;
      in_en_s  = 1'b0;
      in_bit_s = 1'b0;
   endtask

   task automatic wait_done();
      exp_t e;
      int   w = 0;
      while (!obs_done && w < 40) begin
         step();
         w++;
      end
      if (!obs_done) begin
         check("done_timeout", obs_done, 1);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         check("sb_underflow", 0, 1);
      end else begin
         e = sb.pop_front();
         check("ones", obs_ones, e.ones);
         check("result", obs_res, e.result);
         check("latency", cyc - e.start_cyc, e.lat);
         check("busy_at_done", obs_busy, 0);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start_s  = 1'b0;
      in_en_s  = 1'b0;
      in_bit_s = 1'b0;
      sel      = 1'b0;
      cyc      = 0;
      step();
      step();
      check("rst_ones", obs_ones, 0);
      check("rst_result", obs_res, 0);
      check("rst_busy", obs_busy, 0);
      check("rst_done", obs_done, 0);
      rst = 1'b0;
      step();

      // All ones, then all zeros, then alternating.
      run_conv(1'b0, 0, 0, 0, -1);
      wait_done();
      step();
      check("done_one_cycle", obs_done, 0);
      check("busy_idle", obs_busy, 0);
      run_conv(1'b0, 0, 1, 0, -1);
      wait_done();
      step();
      run_conv(1'b0, 0, 2, 0, -1);
      wait_done();

      // Outputs hold while idle, even with traffic on the stream.
      in_en_s  = 1'b1;
      in_bit_s = 1'b1;
      for (int i = 0; i < 4; i++) step();
      in_en_s  = 1'b0;
      in_bit_s = 1'b0;
      check("hold_ones", obs_ones, 8);
      check("hold_result", obs_res, 0);

      // Stall every third cycle.
      run_conv(1'b0, 0, 0, 3, -1);
      wait_done();
      step();

      // SKIP=2 instance: the two ones land in the discarded warm-up.
      run_conv(1'b1, 2, 3, 0, -1);
      wait_done();
      step();
      run_conv(1'b1, 2, 2, 3, -1);
      wait_done();
      step();

      // Start mid-window is ignored; start in the done cycle chains back to back.
      run_conv(1'b0, 0, 2, 0, 8);
      wait_done();
      run_conv(1'b0, 0, 0, 0, -1);
      wait_done();
      run_conv(1'b0, 0, 1, 0, -1);
      wait_done();
      step();
      run_conv(1'b0, 0, 0, 0, -1);
      wait_done();
      step();

      // Reset in the middle of a window.
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_en_s  = 1'b1;
         in_bit_s = 1'b1;
         step();
      end
      check("pre_rst_busy", obs_busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_ones", obs_ones, 0);
      check("mid_rst_result", obs_res, 0);
      check("mid_rst_busy", obs_busy, 0);
      check("mid_rst_done", obs_done, 0);
      in_en_s  = 1'b0;
      in_bit_s = 1'b0;
      step();
      rst = 1'b0;
      step();
      run_conv(1'b0, 0, 2, 0, -1);
      wait_done();
      step();

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
